// File: rtl/shader_line_scheduler_pkg.sv
// rtl/shader_line_scheduler_pkg.sv - shared types and constants for the shader line scheduler
// Contents:
//   state_e          FSM encodings of the fill engine
//   rgb_t            packed {r, g, b} pixel, 8 bits per channel
//   DEF_*            default geometry and per-pixel fallback colour
//   next_line()      fill-line successor with wrap at the last active line
package shader_line_scheduler_pkg;

    localparam int          DEF_H_ACTIVE     = 640;
    localparam int          DEF_V_ACTIVE     = 480;
    localparam int          DEF_TIMEOUT      = 64;
    localparam logic [23:0] DEF_FALLBACK_RGB = 24'hFF00FF;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_COLOR,
        DONE
    } state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Wrap is a compare against the last line, not a modulo.
    function automatic logic [9:0] next_line(input logic [9:0] y, input int v_active);
        return (y >= 10'(v_active - 1)) ? 10'd0 : y + 10'd1;
    endfunction

endpackage

// File: rtl/shader_line_scheduler_if.sv
// rtl/shader_line_scheduler_if.sv - display-side and shader-side signal bundle of the line scheduler
// Signals:
//   line_start/line_y                        display controller line announcement
//   pixel_x/pixel_y/pixel_valid              request to the shader
//   red_in/green_in/blue_in/color_valid      shader result
//   rd_x/rd_data                             display read port
//   line_ready/underrun/color_timeout/underrun_count  status
// Modports: master = scheduler, slave = display controller plus shader.
interface shader_line_scheduler_if;

    logic        line_start;
    logic [9:0]  line_y;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        pixel_valid;
    logic [7:0]  red_in;
    logic [7:0]  green_in;
    logic [7:0]  blue_in;
    logic        color_valid;
    logic [9:0]  rd_x;
    logic [23:0] rd_data;
    logic        line_ready;
    logic        underrun;
    logic        color_timeout;
    logic [15:0] underrun_count;

    modport master (
        input  line_start, line_y, red_in, green_in, blue_in, color_valid, rd_x,
        output pixel_x, pixel_y, pixel_valid, rd_data, line_ready, underrun,
               color_timeout, underrun_count
    );

    modport slave (
        output line_start, line_y, red_in, green_in, blue_in, color_valid, rd_x,
        input  pixel_x, pixel_y, pixel_valid, rd_data, line_ready, underrun,
               color_timeout, underrun_count
    );

endinterface

// File: rtl/shader_line_scheduler_line_bank_ram.sv
// rtl/shader_line_scheduler_line_bank_ram.sv - two-bank line buffer, simple dual port, registered read
// Ports:
//   clk                         clock
//   we/wr_bank/wr_x/wr_data     write port, addressed as {bank, x}
//   rd_bank/rd_x/rd_data        read port, data one cycle after address
// No reset on the storage or read register so it maps onto block RAM.
module line_bank_ram
    import shader_line_scheduler_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE
) (
    input  logic       clk,
    input  logic       we,
    input  logic       wr_bank,
    input  logic [9:0] wr_x,
    input  rgb_t       wr_data,
    input  logic       rd_bank,
    input  logic [9:0] rd_x,
    output rgb_t       rd_data
);

    localparam int DEPTH = 2 * H_ACTIVE;
    localparam int AW    = $clog2(DEPTH);

    rgb_t mem [DEPTH];

    // Banks are packed back to back so depth is exactly two lines.
    function automatic logic [AW-1:0] lin_addr(input logic bank, input logic [9:0] x);
        return bank ? (AW'(H_ACTIVE) + AW'(x)) : AW'(x);
    endfunction

    always_ff @(posedge clk) begin
        if (we) begin
            mem[lin_addr(wr_bank, wr_x)] <= wr_data;
        end
        rd_data <= mem[lin_addr(rd_bank, rd_x)];
    end

endmodule

// File: rtl/shader_line_scheduler.sv
// rtl/shader_line_scheduler.sv - walks one line of pixels through the shader into a ping-pong line buffer
// Ports:
//   clk     clock
//   rst_n   asynchronous active-low reset
//   bus     shader_line_scheduler_if.master (line announce, shader request/result,
//           display read port, line_ready/underrun/color_timeout/underrun_count)
module shader_line_scheduler
    import shader_line_scheduler_pkg::*;
#(
    parameter int          H_ACTIVE     = DEF_H_ACTIVE,
    parameter int          V_ACTIVE     = DEF_V_ACTIVE,
    parameter int          TIMEOUT      = DEF_TIMEOUT,
    parameter logic [23:0] FALLBACK_RGB = DEF_FALLBACK_RGB
) (
    input  logic                    clk,
    input  logic                    rst_n,
    shader_line_scheduler_if.master bus
);

    localparam int TW = $clog2(TIMEOUT);

    state_e         state_q, state_d;
    logic [9:0]     fill_x_q, fill_x_d;
    logic [9:0]     fill_y_q, fill_y_d;
    logic [TW-1:0]  tcnt_q, tcnt_d;
    logic           fill_bank_q, fill_bank_d;
    logic           underrun_q, underrun_d;
    logic           timeout_q;
    logic [15:0]    urun_cnt_q;
    logic           rd_zero_q;

    logic           expired;
    logic           px_done;
    logic           last_px;
    logic           line_complete;
    logic           rd_in_range;
    rgb_t           wr_rgb;
    rgb_t           ram_q;

    assign expired = (state_q == WAIT_COLOR) && !bus.color_valid
                  && (tcnt_q == TW'(TIMEOUT - 1));
    assign px_done = (state_q == WAIT_COLOR) && (bus.color_valid || expired);
    assign last_px = (fill_x_q == 10'(H_ACTIVE - 1));
    // A line_start landing on the edge that commits the last pixel still counts as on time.
    assign line_complete = (state_q == DONE) || (px_done && last_px);

    assign wr_rgb = bus.color_valid ? rgb_t'({bus.red_in, bus.green_in, bus.blue_in})
                                    : rgb_t'(FALLBACK_RGB);

    always_comb begin
        state_d     = state_q;
        fill_x_d    = fill_x_q;
        fill_y_d    = fill_y_q;
        tcnt_d      = tcnt_q;
        fill_bank_d = fill_bank_q;
        underrun_d  = 1'b0;

        case (state_q)
            ISSUE: begin
                tcnt_d  = '0;
                state_d = WAIT_COLOR;
            end
            WAIT_COLOR: begin
                if (px_done) begin
                    if (last_px) begin
                        state_d = DONE;
                    end else begin
                        fill_x_d = fill_x_q + 10'd1;
                        state_d  = ISSUE;
                    end
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: ;
        endcase

        // line_start overrides normal sequencing: the fill always restarts at x = 0.
        if (bus.line_start) begin
            if (line_complete) begin
                fill_bank_d = ~fill_bank_q;
            end else if (state_q != IDLE) begin
                underrun_d = 1'b1;
            end
            fill_x_d = '0;
            fill_y_d = next_line(bus.line_y, V_ACTIVE);
            state_d  = ISSUE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fill_x_q    <= '0;
            fill_y_q    <= '0;
            tcnt_q      <= '0;
            fill_bank_q <= 1'b0;
            underrun_q  <= 1'b0;
            timeout_q   <= 1'b0;
            urun_cnt_q  <= '0;
            rd_zero_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            fill_x_q    <= fill_x_d;
            fill_y_q    <= fill_y_d;
            tcnt_q      <= tcnt_d;
            fill_bank_q <= fill_bank_d;
            underrun_q  <= underrun_d;
            timeout_q   <= expired;
            if (underrun_d && (urun_cnt_q != 16'hFFFF)) begin
                urun_cnt_q <= urun_cnt_q + 16'd1;
            end
            rd_zero_q   <= !rd_in_range;
        end
    end

    // Out-of-range reads are steered to a legal address and masked after the RAM register.
    assign rd_in_range = (bus.rd_x < 10'(H_ACTIVE));

    line_bank_ram #(
        .H_ACTIVE (H_ACTIVE)
    ) u_ram (
        .clk     (clk),
        .we      (px_done),
        .wr_bank (fill_bank_q),
        .wr_x    (fill_x_q),
        .wr_data (wr_rgb),
        .rd_bank (~fill_bank_q),
        .rd_x    (rd_in_range ? bus.rd_x : 10'd0),
        .rd_data (ram_q)
    );

    // fill_x/fill_y only change on the way into ISSUE, so they double as the held coordinates.
    assign bus.pixel_x        = fill_x_q;
    assign bus.pixel_y        = fill_y_q;
    assign bus.pixel_valid    = (state_q == ISSUE);
    assign bus.line_ready     = (state_q == DONE);
    assign bus.underrun       = underrun_q;
    assign bus.color_timeout  = timeout_q;
    assign bus.underrun_count = urun_cnt_q;
    assign bus.rd_data        = rd_zero_q ? 24'h0 : ram_q;

endmodule

// File: tb/tb_shader_line_scheduler.sv
// tb/tb_shader_line_scheduler.sv - scoreboard bench for shader_line_scheduler
module tb_shader_line_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shader_line_scheduler_if bus();

    shader_line_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [23:0] exp_q [$];
    logic [9:0]  addr_q [$];
    logic [23:0] exp_v;
    logic [9:0]  exp_a;
    logic        rd_req = 1'b0;
    logic        rd_pend = 1'b0;

    always @(posedge clk) begin
        rd_pend <= rd_req;
        cyc     <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every read issued one cycle earlier pops its expected value.
    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got %0h expected none", bus.rd_data);
            end else begin
                exp_v = exp_q.pop_front();
                exp_a = addr_q.pop_front();
                check($sformatf("rd_data[x=%0d]", exp_a), 32'(bus.rd_data), 32'(exp_v));
            end
        end
    end

    // Model shader: 3-cycle latency, colour {x, y, 55}; optionally never answers drop_x.
    int         lat = 0;
    logic [9:0] sx, sy;
    logic       drop_en = 1'b0;
    logic [9:0] drop_x = 10'd5;

    initial begin
        bus.color_valid = 1'b0;
        bus.red_in      = '0;
        bus.green_in    = '0;
        bus.blue_in     = '0;
        forever begin
            @(negedge clk);
            bus.color_valid = 1'b0;
            if (lat > 0) begin
                lat--;
                if (lat == 0) begin
                    bus.color_valid = 1'b1;
                    bus.red_in      = sx[7:0];
                    bus.green_in    = sy[7:0];
                    bus.blue_in     = 8'h55;
                end
            end
            if (bus.pixel_valid === 1'b1) begin
                if (drop_en && bus.pixel_x == drop_x) begin
                    lat = 0;
                end else begin
                    lat = 3;
                    sx  = bus.pixel_x;
                    sy  = bus.pixel_y;
                end
            end
        end
    end

    int t_pv5 = -1;
    int t_to = -1;
    int n_to = 0;

    always @(negedge clk) begin
        if (bus.pixel_valid === 1'b1 && bus.pixel_x == 10'd5 && drop_en) t_pv5 = cyc;
        if (bus.color_timeout === 1'b1) begin
            n_to++;
            t_to = cyc;
        end
    end

    task automatic pulse_start(input logic [9:0] y);
        bus.line_start = 1'b1;
        bus.line_y     = y;
        @(negedge clk);
        bus.line_start = 1'b0;
    endtask

    task automatic rd(input logic [9:0] a, input logic [23:0] e);
        bus.rd_x = a;
        rd_req   = 1'b1;
        exp_q.push_back(e);
        addr_q.push_back(a);
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (bus.line_ready !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("line_ready_wait", 32'(bus.line_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pixel_valid"},    32'(bus.pixel_valid),    32'd0);
        check({tag, "_pixel_x"},        32'(bus.pixel_x),        32'd0);
        check({tag, "_pixel_y"},        32'(bus.pixel_y),        32'd0);
        check({tag, "_rd_data"},        32'(bus.rd_data),        32'd0);
        check({tag, "_line_ready"},     32'(bus.line_ready),     32'd0);
        check({tag, "_underrun"},       32'(bus.underrun),       32'd0);
        check({tag, "_color_timeout"},  32'(bus.color_timeout),  32'd0);
        check({tag, "_underrun_count"}, 32'(bus.underrun_count), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int pv;
        bus.line_start = 1'b0;
        bus.line_y     = '0;
        bus.rd_x       = '0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // First start from IDLE: fill line 1, no underrun.
        pulse_start(10'd0);
        check("first_underrun", 32'(bus.underrun), 32'd0);
        check("first_pixel_valid", 32'(bus.pixel_valid), 32'd1);
        check("first_pixel_x", 32'(bus.pixel_x), 32'd0);
        check("first_pixel_y", 32'(bus.pixel_y), 32'd1);
        wait_ready(4000);

        // On-time start: swap, line 1 becomes visible.
        pulse_start(10'd1);
        check("swap_underrun", 32'(bus.underrun), 32'd0);
        check("swap_pixel_y", 32'(bus.pixel_y), 32'd2);
        check("swap_line_ready", 32'(bus.line_ready), 32'd0);
        rd(10'd10,  24'h0A0155);
        rd(10'd0,   24'h000155);
        rd(10'd639, 24'h7F0155);
        rd(10'd640, 24'h000000);

        // Early start: underrun, no swap, restart at line 3.
        repeat (490) @(negedge clk);
        drop_en = 1'b1;
        pulse_start(10'd2);
        check("urun_pulse", 32'(bus.underrun), 32'd1);
        check("urun_count", 32'(bus.underrun_count), 32'd1);
        check("urun_pixel_valid", 32'(bus.pixel_valid), 32'd1);
        check("urun_pixel_x", 32'(bus.pixel_x), 32'd0);
        check("urun_pixel_y", 32'(bus.pixel_y), 32'd3);
        rd(10'd10, 24'h0A0155);
        check("urun_pulse_once", 32'(bus.underrun), 32'd0);

        // Line 3 with pixel 5 unanswered.
        wait_ready(4000);
        check("timeout_count", n_to, 1);
        check("timeout_latency", t_to - t_pv5, 65);
        drop_en = 1'b0;
        pulse_start(10'd3);
        check("to_swap_underrun", 32'(bus.underrun), 32'd0);
        rd(10'd5, 24'hFF00FF);
        rd(10'd4, 24'h040355);
        rd(10'd6, 24'h060355);

        // Last line wraps the fill to line 0.
        wait_ready(4000);
        pulse_start(10'd479);
        check("wrap_pixel_y", 32'(bus.pixel_y), 32'd0);
        check("wrap_underrun", 32'(bus.underrun), 32'd0);
        rd(10'd5,    24'h050455);
        rd(10'd1023, 24'h000000);

        // line_start on the same edge as the last colour_valid: on time.
        n = 0;
        while (!(bus.pixel_valid === 1'b1 && bus.pixel_x == 10'd639) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("last_pixel_seen", 32'(bus.pixel_x), 32'd639);
        repeat (3) @(negedge clk);
        pulse_start(10'd0);
        check("coinc_underrun", 32'(bus.underrun), 32'd0);
        check("coinc_count", 32'(bus.underrun_count), 32'd1);
        check("coinc_pixel_valid", 32'(bus.pixel_valid), 32'd1);
        check("coinc_pixel_y", 32'(bus.pixel_y), 32'd1);
        rd(10'd639, 24'h7F0055);
        rd(10'd10,  24'h0A0055);

        // Reset mid-fill.
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        pv = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.pixel_valid === 1'b1) pv++;
        end
        check("post_reset_idle_requests", pv, 0);
        check("post_reset_line_ready", 32'(bus.line_ready), 32'd0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
